// File: rtl/iexecute_memory_if.sv
// iexecute_memory_if: decoded-instruction bundle in, branch resolution and
// write-back results out. The master side is the decode stage / testbench,
// the slave side is iexecute_memory.
// Optional feature macro: IEXEC_ILLEGAL_TRAP_EN adds the sticky illegal_op flag.
interface iexecute_memory_if #(
    parameter int WORD = 64
);
    // Decoded instruction bundle
    logic             in_valid;
    logic [WORD-1:0]  cur_pc;
    logic [WORD-1:0]  read_data1;
    logic [WORD-1:0]  read_data2;
    logic [WORD-1:0]  ext_addr;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic [10:0]      alu_con_instr;
    logic             branch;
    logic             uncondbranch;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;

    // Results returned to the front end
    logic             pc_src;
    logic [WORD-1:0]  branch_target;
    logic [WORD-1:0]  write_data;
    logic             wb_valid;
`ifdef IEXEC_ILLEGAL_TRAP_EN
    logic             illegal_op;
`endif

    modport master (
        output in_valid, cur_pc, read_data1, read_data2, ext_addr,
               alu_src, alu_op, alu_con_instr, branch, uncondbranch,
               mem_read, mem_write, mem_to_reg,
        input  pc_src, branch_target, write_data, wb_valid
`ifdef IEXEC_ILLEGAL_TRAP_EN
               , illegal_op
`endif
    );

    modport slave (
        input  in_valid, cur_pc, read_data1, read_data2, ext_addr,
               alu_src, alu_op, alu_con_instr, branch, uncondbranch,
               mem_read, mem_write, mem_to_reg,
        output pc_src, branch_target, write_data, wb_valid
`ifdef IEXEC_ILLEGAL_TRAP_EN
               , illegal_op
`endif
    );
endinterface

// File: rtl/iexecute_memory.sv
// iexecute_memory: EX / MEM / WB back end of the core.
//   EX  : ALU and branch resolve, registered at the clk edge.
//   MEM : data memory access and write-back select, registered at the clk edge.
// Latency: in_valid -> pc_src/branch_target 1 cycle, in_valid -> wb_valid 2 cycles.
// Optional feature macro: IEXEC_ILLEGAL_TRAP_EN
//   defined   : sticky illegal_op output, offending op's write-back suppressed.
//   undefined : illegal encodings write back 0 with wb_valid = 1.
module iexecute_memory #(
    parameter int WORD       = 64,
    parameter int DMEM_DEPTH = 32,
    parameter int DMEM_AW    = 5
) (
    input  logic               clk,
    input  logic               reset,
    iexecute_memory_if.slave   bus
);

    // R-type opcode encodings
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    localparam logic [1:0]  ALUOP_ADD   = 2'b00;
    localparam logic [1:0]  ALUOP_PASSB = 2'b01;
    localparam logic [1:0]  ALUOP_RTYPE = 2'b10;

    // ------------------------------------------------------------------
    // EX stage: combinational
    // ------------------------------------------------------------------
    logic [WORD-1:0] op_b_s;
    logic [WORD-1:0] alu_result_s;
    logic            zero_s;
    logic [WORD-1:0] branch_target_s;
    logic            pc_src_s;
    logic            ex_valid_s;

    // ALU operand select, result and zero test
    always_comb begin
        op_b_s       = bus.alu_src ? bus.ext_addr : bus.read_data2;
        alu_result_s = {WORD{1'b0}};
        zero_s       = 1'b0;
        case (bus.alu_op)
            ALUOP_ADD: begin
                alu_result_s = bus.read_data1 + op_b_s;
            end
            ALUOP_PASSB: begin
                alu_result_s = op_b_s;
                zero_s       = (op_b_s == {WORD{1'b0}});
            end
            ALUOP_RTYPE: begin
                case (bus.alu_con_instr)
                    OPC_ADD: alu_result_s = bus.read_data1 + op_b_s;
                    OPC_SUB: alu_result_s = bus.read_data1 - op_b_s;
                    OPC_AND: alu_result_s = bus.read_data1 & op_b_s;
                    OPC_ORR: alu_result_s = bus.read_data1 | op_b_s;
                    default: alu_result_s = {WORD{1'b0}};
                endcase
            end
            default: begin
                alu_result_s = {WORD{1'b0}};
            end
        endcase
    end

    // Branch target is PC plus the word offset; taken only for a valid instruction
    always_comb begin
        branch_target_s = bus.cur_pc + {bus.ext_addr[WORD-3:0], 2'b00};
        pc_src_s        = bus.in_valid & (bus.uncondbranch | (bus.branch & zero_s));
    end

`ifdef IEXEC_ILLEGAL_TRAP_EN
    logic illegal_s;
    logic illegal_op_r;

    // True for R-type opcodes the ALU implements
    function automatic logic rtype_legal(input logic [10:0] code);
        case (code)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR: rtype_legal = 1'b1;
            default:                            rtype_legal = 1'b0;
        endcase
    endfunction

    // Flag reserved alu_op and undecoded R-type opcodes; such ops never write back
    always_comb begin
        illegal_s = 1'b0;
        if (bus.alu_op == 2'b11) begin
            illegal_s = 1'b1;
        end else if (bus.alu_op == ALUOP_RTYPE) begin
            illegal_s = ~rtype_legal(bus.alu_con_instr);
        end else begin
            illegal_s = 1'b0;
        end
        ex_valid_s = bus.in_valid & ~illegal_s;
    end

    // Sticky illegal-operation flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_op_r <= 1'b0;
        end else if (bus.in_valid & illegal_s) begin
            illegal_op_r <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal_op_r;
`else
    // Every valid instruction proceeds, illegal encodings carry a zero result
    always_comb begin
        ex_valid_s = bus.in_valid;
    end
`endif

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    logic            pc_src_r;
    logic [WORD-1:0] branch_target_r;
    logic            ex_valid_r;
    logic [WORD-1:0] ex_result_r;
    logic [WORD-1:0] ex_store_data_r;
    logic            ex_mem_read_r;
    logic            ex_mem_write_r;
    logic            ex_mem_to_reg_r;

    // Branch outputs update every cycle; the payload only on a valid instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_src_r        <= 1'b0;
            branch_target_r <= {WORD{1'b0}};
            ex_valid_r      <= 1'b0;
            ex_result_r     <= {WORD{1'b0}};
            ex_store_data_r <= {WORD{1'b0}};
            ex_mem_read_r   <= 1'b0;
            ex_mem_write_r  <= 1'b0;
            ex_mem_to_reg_r <= 1'b0;
        end else begin
            pc_src_r        <= pc_src_s;
            branch_target_r <= branch_target_s;
            ex_valid_r      <= ex_valid_s;
            if (bus.in_valid) begin
                ex_result_r     <= alu_result_s;
                ex_store_data_r <= bus.read_data2;
                ex_mem_read_r   <= bus.mem_read;
                ex_mem_write_r  <= bus.mem_write;
                ex_mem_to_reg_r <= bus.mem_to_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // MEM stage: data memory
    // ------------------------------------------------------------------
    logic [WORD-1:0]    dmem_r [DMEM_DEPTH];
    logic [DMEM_AW-1:0] dmem_idx_s;
    logic [WORD-1:0]    dmem_rdata_s;
    logic [WORD-1:0]    wb_data_s;
    logic               wb_update_s;

    // Doubleword index: byte offset dropped, upper address bits wrap
    always_comb begin
        dmem_idx_s = ex_result_r[DMEM_AW+2:3];
        if (ex_mem_read_r) begin
            dmem_rdata_s = dmem_r[dmem_idx_s];
        end else begin
            dmem_rdata_s = {WORD{1'b0}};
        end
        wb_data_s   = ex_mem_to_reg_r ? dmem_rdata_s : ex_result_r;
        wb_update_s = ex_valid_r & ~ex_mem_write_r;
    end

    // Store port; the combinational read above sees the pre-store value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_r[i] <= {WORD{1'b0}};
            end
        end else if (ex_valid_r & ex_mem_write_r) begin
            dmem_r[dmem_idx_s] <= ex_store_data_r;
        end
    end

    // ------------------------------------------------------------------
    // Write-back register
    // ------------------------------------------------------------------
    logic [WORD-1:0] write_data_r;
    logic            wb_valid_r;

    // Stores and bubbles leave write_data untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_data_r <= {WORD{1'b0}};
            wb_valid_r   <= 1'b0;
        end else begin
            wb_valid_r <= wb_update_s;
            if (wb_update_s) begin
                write_data_r <= wb_data_s;
            end
        end
    end

    assign bus.pc_src        = pc_src_r;
    assign bus.branch_target = branch_target_r;
    assign bus.write_data    = write_data_r;
    assign bus.wb_valid      = wb_valid_r;

endmodule

// File: doc/iexecute_memory.md
Name: iexecute_memory

Overview:
- Execute, memory and write-back end of the fetch/decode datapath.
- Consumes the decoded operands and control bundle; produces the three signals the front end consumes: pc_src, branch_target, write_data.
- Two-stage pipelined: EX (ALU, branch resolve) registered, then MEM (data memory access, write-back select) registered.
- Holds the core's data memory.

Parameters:
- WORD, 64, datapath width in bits.
- DMEM_DEPTH, 32, data memory depth in doublewords; power of two.
- DMEM_AW, 5, log2(DMEM_DEPTH).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded instruction present this cycle.
- cur_pc  input  WORD  PC of the decoded instruction.
- read_data1  input  WORD  register operand Rn.
- read_data2  input  WORD  register operand Rm/Rt.
- ext_addr  input  WORD  sign-extended immediate or offset.
- alu_src  input  1  0 = read_data2, 1 = ext_addr as ALU operand B.
- alu_op  input  2  00 add, 01 pass-B/zero-test, 10 R-type via alu_con_instr, 11 reserved.
- alu_con_instr  input  11  opcode field for R-type.
- branch  input  1  conditional branch (CBZ).
- uncondbranch  input  1  unconditional branch (B).
- mem_read  input  1  load.
- mem_write  input  1  store.
- mem_to_reg  input  1  write-back from memory, else from ALU.
- pc_src  output  1  take branch_target.
- branch_target  output  WORD  resolved branch address.
- write_data  output  WORD  register-file write-back value.
- wb_valid  output  1  write_data is valid this cycle.

Behaviour:
- Reset, asynchronous, while asserted:
  - pc_src = 0, branch_target = 0, write_data = 0, wb_valid = 0.
  - All pipeline registers cleared.
  - All DMEM entries = 0.
- ALU, combinational in EX:
  - A = read_data1; B = alu_src ? ext_addr : read_data2.
  - alu_op 00: A + B.
  - alu_op 01: result = B; zero = (B == 0).
  - alu_op 10, by alu_con_instr: 10001011000 ADD, 11001011000 SUB (A - B), 10001010000 AND, 10101010000 ORR. Any other code gives result 0.
  - alu_op 11: result 0.
  - Arithmetic is modulo 2^WORD; no flags.
- Branch:
  - branch_target = cur_pc + (ext_addr << 2), modulo 2^WORD.
  - pc_src = in_valid & (uncondbranch | (branch & zero)).
- EX register, latched at the clk edge:
  - Always: pc_src and branch_target, so both are valid one cycle after in_valid.
  - When in_valid: ALU result, read_data2, mem_read, mem_write, mem_to_reg, and a stage-valid bit.
  - When in_valid = 0: stage-valid clears; pc_src goes 0.
- MEM stage:
  - DMEM index = alu_result[DMEM_AW+2:3]. Low 3 bits are ignored (misaligned access rounds down). Upper bits are ignored, so addresses wrap modulo DMEM_DEPTH*8.
  - Store: DMEM[index] <= stored read_data2 at the clk edge, when stage-valid & mem_write.
  - Load: combinational read of DMEM[index].
  - mem_read & mem_write both set: the old value is read, then the write is performed.
- Write-back register, latched at the clk edge:
  - write_data <= mem_to_reg ? dmem_rdata : alu_result.
  - wb_valid <= stage-valid & ~mem_write.
  - Stores do not update write_data.
- Latency: in_valid to wb_valid is 2 cycles. in_valid to pc_src is 1 cycle.
- Throughput: one instruction per cycle.
- A store followed by a load to the same address in the next cycle returns the stored data; the write lands before the load's MEM cycle.
- No hazard detection or forwarding: the producer guarantees operand readiness.
- Reset mid-operation drops all in-flight instructions; DMEM contents are lost.

Optional Feature:
- Macro: IEXEC_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_op (1 bit).
  - illegal_op is sticky: set at the clk edge when in_valid and either alu_op = 11, or alu_op = 10 with an undecoded alu_con_instr.
  - Once set, it holds until reset.
  - The offending instruction's wb_valid is suppressed.
- Undefined:
  - No port.
  - Illegal encodings write back 0 with wb_valid = 1.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, release → all outputs 0 for 5 cycles; pc_src never 1.
- R-type: A=7, B=5, alu_op=10, codes ADD/SUB/AND/ORR on consecutive cycles → write_data 12, 2, 5, 7 on cycles +2..+5, wb_valid=1 each.
- Store/load: STUR Rt=0xDEADBEEF, A=0x40, ext_addr=8 (address 0x48), next cycle LDUR at the same address with mem_to_reg=1 → write_data=0xDEADBEEF at load+2. Store produces no wb_valid.
- Address wrap: store 0x1234 at address 0x100 (index 0 with depth 32), load address 0x0 → write_data 0x1234.
- CBZ with cur_pc=0x20, ext_addr=3:
  - read_data2=0 → pc_src=1, branch_target=0x2C one cycle later.
  - read_data2=1 → pc_src=0.
  - B with ext_addr=-2 (all ones then 0xE) → branch_target=0x18.
- IEXEC_ILLEGAL_TRAP_EN: alu_op=10 with alu_con_instr=0 → illegal_op=1 next cycle and stays 1 through 10 legal ops; that op's wb_valid=0; reset clears illegal_op.
